spi_burst_ctrl: RTL and testbench
=================================

# spi_burst_ctrl

Transaction sequencer that sits directly upstream of the SPI byte shifter. It buffers host bytes in a TX FIFO and frames a multi-byte burst with chip-select. It hands bytes to the shifter one at a time over its wr/done handshake and collects each received byte into an RX FIFO. The host sees a FIFO-plus-start interface; the shifter sees one byte per handshake.

## Interface
- DEPTH, 16: entries per FIFO; power of two, ≥2
- LEN_W, 8: width of burst length
- CS_SETUP_CYC, 2: cycles cs_n is low before the first byte (≥1)
- CS_HOLD_CYC, 2: cycles cs_n stays low after the last byte completes (≥1)
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- tx_push  in  1  write tx_data into TX FIFO; ignored when tx_full
- tx_data  in  8  byte to transmit
- tx_full  out  1  TX FIFO full
- start  in  1  begin burst of len bytes; accepted only when busy=0
- len  in  LEN_W  byte count; 0 means start is ignored
- busy  out  1  burst in progress (start accepted … return to IDLE)
- xfer_done  out  1  one-cycle pulse on return to IDLE
- rx_pop  in  1  consume rx_data; ignored when rx_valid=0
- rx_data  out  8  head of RX FIFO (show-ahead)
- rx_valid  out  1  RX FIFO not empty
- rx_ovf  out  1  sticky: a received byte was dropped because RX FIFO was full
- cs_n  out  1  SPI chip select, active low
- eng_wr  out  1  to shifter wr
- eng_data  out  8  to shifter data_in
- eng_done  in  1  from shifter done (high = idle)
- eng_rdata  in  8  from shifter data_out

## Operation
- States: IDLE, SETUP, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
- IDLE: cs_n=1. start with len≠0 → latch remaining=len, clear rx_ovf, busy=1, go to SETUP. Start with len=0 has no effect.
- SETUP: cs_n=0; count CS_SETUP_CYC cycles, then go to LOAD.
- LOAD: if the TX FIFO is non-empty, pop the head, drive eng_wr=1 and eng_data=head for exactly one cycle, and go to WAIT_BUSY. If it is empty, stall in LOAD with cs_n held low (underflow is not an error).
- WAIT_BUSY: wait for eng_done=0, which shows the shifter accepted the byte, then go to WAIT_DONE.
- WAIT_DONE: wait for eng_done=1. In that cycle, push eng_rdata into the RX FIFO; if the RX FIFO is full, drop the byte and set rx_ovf. Then decrement remaining: if it reaches 0 go to HOLD, else go to LOAD.
- HOLD: cs_n=0 for CS_HOLD_CYC cycles, then go to IDLE, pulse xfer_done and drop busy.
- remaining is LEN_W bits. It is decremented only in WAIT_DONE and never wraps.
- Simultaneous tx_push and internal pop: both occur, so the count is unchanged, and a full FIFO still accepts the push. The same rule applies to rx_pop with an internal push.
- start while busy=1 is ignored.
- Reset mid-burst: all state returns to reset values immediately, cs_n goes high asynchronously and both FIFOs are emptied. The shifter is not reset by this block.

## Timing
- Reset values: cs_n=1, eng_wr=0, eng_data=0, busy=0, xfer_done=0, tx_full=0, rx_valid=0, rx_ovf=0, rx_data=0.
- All outputs are registered except rx_data and rx_valid, which come from FIFO registers.
- start sampled at edge N → busy=1 and cs_n=0 from N+1. The first eng_wr pulse follows at N+1+CS_SETUP_CYC if TX data is present.
- Between bytes, cs_n stays low and there is one LOAD cycle of gap after eng_done rises.
- A pushed byte is visible to LOAD on the cycle after tx_push. A received byte raises rx_valid on the cycle after WAIT_DONE exits.

## Configuration
- SPI_BURST_RXFIFO_EN defined: the RX FIFO is instantiated as described.
- Not defined: received bytes are discarded, rx_valid=0, rx_data=0 and rx_ovf=0 permanently, and rx_pop is ignored. TX behaviour and timing are identical in both builds.

## Structure
- Shared package spi_burst_pkg holds:
  - the state enum (the six states above)
  - the constant default DEPTH
  - the byte width constant (8).
- One sub-module, spi_fifo (parameter DEPTH, 8-bit, show-ahead, async reset), instantiated for TX and, conditionally, for RX.

## Test plan
- Push 0xA5,0x3C; start len=2 with the shifter model looping mosi→miso → two eng_wr pulses carrying 0xA5 then 0x3C; rx_data reads 0xA5 then 0x3C; one xfer_done; cs_n low for setup+2 bytes+hold.
- start len=3 with only 1 byte queued → controller stalls in LOAD with cs_n=0; pushing 2 more bytes 50 cycles later → burst completes with 3 RX bytes.
- DEPTH=4, burst of 6 with rx_pop never asserted → 4 bytes are kept, rx_ovf=1 after the 5th; a new start clears rx_ovf.
- Assert rst during the 2nd byte of a 4-byte burst → cs_n=1 and busy=0 in the same cycle, FIFOs are empty, and no xfer_done pulse.
- start with len=0, and start while busy → no state change, cs_n stays as it was, and no extra eng_wr.
- Build without SPI_BURST_RXFIFO_EN and run a 2-byte burst → TX waveform is identical to the first scenario; rx_valid stays 0.

Source files
------------

// File: rtl/spi_burst_pkg.sv
// Shared types and constants for the SPI burst sequencer.
package spi_burst_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int BYTE_W        = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_HOLD
  } state_t;

endpackage

// File: rtl/spi_burst_ctrl_if.sv
// Host and shifter signals of spi_burst_ctrl, bundled with master/slave views.
//
// Handshakes:
//   tx_push/tx_full : a byte is taken on any edge where tx_push=1 and either
//                     tx_full=0 or the controller pops in that same cycle.
//   rx_valid/rx_pop : rx_data is the head; it is consumed on any edge where
//                     rx_pop=1 and rx_valid=1.
//   eng_wr/eng_done : eng_wr pulses one cycle with eng_data; the shifter
//                     acknowledges by dropping eng_done, and the byte is
//                     complete (eng_rdata valid) when eng_done rises again.
interface spi_burst_ctrl_if #(parameter int LEN_W = 8) ();
  import spi_burst_pkg::*;

  logic              tx_push;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_full;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              xfer_done;
  logic              rx_pop;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ovf;
  logic              cs_n;
  logic              eng_wr;
  logic [BYTE_W-1:0] eng_data;
  logic              eng_done;
  logic [BYTE_W-1:0] eng_rdata;

  // Controller side
  modport slave (
    input  tx_push, tx_data, start, len, rx_pop, eng_done, eng_rdata,
    output tx_full, busy, xfer_done, rx_data, rx_valid, rx_ovf,
           cs_n, eng_wr, eng_data
  );

  // Host / shifter side
  modport master (
    output tx_push, tx_data, start, len, rx_pop, eng_done, eng_rdata,
    input  tx_full, busy, xfer_done, rx_data, rx_valid, rx_ovf,
           cs_n, eng_wr, eng_data
  );

endinterface

// File: rtl/spi_fifo.sv
// Byte-wide show-ahead FIFO with async reset. A push into a full FIFO is
// accepted when a pop happens in the same cycle.
module spi_fifo
  import spi_burst_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next pointers, occupancy and storage contents
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Storage is cleared on reset so the show-ahead head reads zero when empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of the SPI byte shifter: buffers TX bytes, frames
// a burst with cs_n, feeds the shifter one byte per wr/done handshake and
// collects received bytes. Define SPI_BURST_RXFIFO_EN to build the RX FIFO;
// without it received bytes are discarded and the RX outputs stay zero.
module spi_burst_ctrl
  import spi_burst_pkg::*;
#(
  parameter int DEPTH        = DEFAULT_DEPTH,
  parameter int LEN_W        = 8,
  parameter int CS_SETUP_CYC = 2,
  parameter int CS_HOLD_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  spi_burst_ctrl_if.slave  bus,
  output state_t           dbg_state
);

  localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The LOAD cycle before the first eng_wr counts as one setup cycle.
  localparam logic [CNT_W-1:0] SETUP_INIT = CNT_W'((CS_SETUP_CYC > 1) ? CS_SETUP_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'(CS_HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              xfer_done_q, xfer_done_d;
  logic              eng_wr_q, eng_wr_d;
  logic [BYTE_W-1:0] eng_data_q, eng_data_d;
  logic              rx_ovf_q, rx_ovf_d;

  logic              tx_pop, tx_full, tx_empty;
  logic [BYTE_W-1:0] tx_head;
  logic              rx_push, rx_drop;

  spi_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.tx_push),
    .din   (bus.tx_data),
    .pop   (tx_pop),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

`ifdef SPI_BURST_RXFIFO_EN
  logic rx_full, rx_empty;

  spi_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (bus.eng_rdata),
    .pop   (bus.rx_pop),
    .dout  (bus.rx_data),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign bus.rx_valid = !rx_empty;
  // A full FIFO still takes the byte if the host pops in the same cycle
  assign rx_drop      = rx_full && !bus.rx_pop;
`else
  logic unused_rx;
  assign unused_rx    = ^{rx_push, bus.eng_rdata, bus.rx_pop};
  assign bus.rx_data  = '0;
  assign bus.rx_valid = 1'b0;
  assign rx_drop      = 1'b0;
`endif

  // Sequencer next state, counters and registered outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    rx_ovf_d    = rx_ovf_q;
    eng_wr_d    = 1'b0;
    eng_data_d  = eng_data_q;
    xfer_done_d = 1'b0;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.len != '0)) begin
          remaining_d = bus.len;
          rx_ovf_d    = 1'b0;
          cnt_d       = SETUP_INIT;
          state_d     = (CS_SETUP_CYC > 1) ? S_SETUP : S_LOAD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) state_d = S_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LOAD: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          eng_wr_d   = 1'b1;
          eng_data_d = tx_head;
          state_d    = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!bus.eng_done) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (bus.eng_done) begin
          rx_push = 1'b1;
          if (rx_drop) rx_ovf_d = 1'b1;
          if (remaining_q != '0) remaining_d = remaining_q - 1'b1;
          if (remaining_q <= LEN_W'(1)) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_INIT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          xfer_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cs_n_d = (state_d == S_IDLE);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset raises cs_n immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      remaining_q <= '0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
      eng_wr_q    <= 1'b0;
      eng_data_q  <= '0;
      rx_ovf_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      xfer_done_q <= xfer_done_d;
      eng_wr_q    <= eng_wr_d;
      eng_data_q  <= eng_data_d;
      rx_ovf_q    <= rx_ovf_d;
    end
  end

  assign bus.tx_full   = tx_full;
  assign bus.busy      = busy_q;
  assign bus.xfer_done = xfer_done_q;
  assign bus.rx_ovf    = rx_ovf_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.eng_wr    = eng_wr_q;
  assign bus.eng_data  = eng_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Directed bench for spi_burst_ctrl (DEPTH=4, setup/hold 2) with a loopback
// shifter model and a TX byte scoreboard.
module tb_spi_burst_ctrl;
  import spi_burst_pkg::*;

  localparam int DEPTH     = 4;
  localparam int SHIFT_CYC = 4;
`ifdef SPI_BURST_RXFIFO_EN
  localparam bit RX_EN = 1'b1;
`else
  localparam bit RX_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_burst_ctrl_if #(.LEN_W(8)) bus ();
  state_t dbg_state;

  spi_burst_ctrl #(
    .DEPTH(DEPTH), .LEN_W(8), .CS_SETUP_CYC(2), .CS_HOLD_CYC(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  int cs_low_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Shifter model: accept on eng_wr, busy for SHIFT_CYC cycles, echo the byte
  initial begin
    logic [7:0] shift_byte;
    bus.eng_done  = 1'b1;
    bus.eng_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.eng_wr === 1'b1) begin
        shift_byte   = bus.eng_data;
        bus.eng_done = 1'b0;
        repeat (SHIFT_CYC) @(negedge clk);
        bus.eng_rdata = shift_byte;
        bus.eng_done  = 1'b1;
      end
    end
  end

  // Monitor: score every eng_wr byte, count pulses and cs_n low cycles
  initial begin
    forever begin
      @(negedge clk);
      if (bus.eng_wr === 1'b1) begin
        wr_cnt++;
        check("eng_wr_queued", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) check("eng_data", 32'(bus.eng_data), 32'(exp_q.pop_front()));
      end
      if (bus.xfer_done === 1'b1) done_cnt++;
      if (bus.cs_n === 1'b0) cs_low_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input bit accept);
    @(negedge clk);
    bus.tx_push = 1'b1;
    bus.tx_data = b;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    bus.tx_push = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = 8'd0;
  endtask

  task automatic rx_expect(input string tag, input logic [7:0] v);
    check({tag, "_valid"}, 32'(bus.rx_valid), 32'(RX_EN));
    check({tag, "_data"}, 32'(bus.rx_data), RX_EN ? 32'(v) : 32'd0);
    @(negedge clk);
    bus.rx_pop = 1'b1;
    @(negedge clk);
    bus.rx_pop = 1'b0;
  endtask

  task automatic wait_xfer_done(input string tag, input int budget);
    int k = 0;
    while (bus.xfer_done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_xfer_done"}, 32'(bus.xfer_done), 32'd1);
    check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
    check({tag, "_cs_high"}, 32'(bus.cs_n), 32'd1);
    @(negedge clk);
  endtask

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s_wr, s_done, s_cs, k;
    bus.tx_push = 1'b0;
    bus.tx_data = 8'h00;
    bus.start   = 1'b0;
    bus.len     = 8'd0;
    bus.rx_pop  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("rst_eng_wr", 32'(bus.eng_wr), 32'd0);
    check("rst_eng_data", 32'(bus.eng_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_xfer_done", 32'(bus.xfer_done), 32'd0);
    check("rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_ovf", 32'(bus.rx_ovf), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    rst = 1'b0;

    // 1: two-byte loopback burst
    push_byte(8'hA5, 1'b1);
    push_byte(8'h3C, 1'b1);
    s_wr = wr_cnt; s_done = done_cnt; s_cs = cs_low_cnt;
    start_burst(8'd2);
    check("b1_busy", 32'(bus.busy), 32'd1);
    check("b1_cs_low", 32'(bus.cs_n), 32'd0);
    k = 0;
    while (bus.eng_wr !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("b1_setup_latency", 32'(k), 32'd2);
    wait_xfer_done("b1", 200);
    check("b1_wr_count", 32'(wr_cnt - s_wr), 32'd2);
    check("b1_done_count", 32'(done_cnt - s_done), 32'd1);
    check("b1_cs_low_cycles", 32'(cs_low_cnt - s_cs), 32'd15);
    rx_expect("b1_rx0", 8'hA5);
    rx_expect("b1_rx1", 8'h3C);
    check("b1_rx_empty", 32'(bus.rx_valid), 32'd0);

    // 2: underflow stall in LOAD, then completion
    push_byte(8'h11, 1'b1);
    s_wr = wr_cnt; s_done = done_cnt;
    start_burst(8'd3);
    repeat (50) @(negedge clk);
    check("b2_stall_state", 32'(dbg_state), 32'(S_LOAD));
    check("b2_stall_cs", 32'(bus.cs_n), 32'd0);
    check("b2_stall_wr", 32'(wr_cnt - s_wr), 32'd1);
    push_byte(8'h22, 1'b1);
    push_byte(8'h33, 1'b1);
    wait_xfer_done("b2", 300);
    check("b2_wr_count", 32'(wr_cnt - s_wr), 32'd3);
    check("b2_done_count", 32'(done_cnt - s_done), 32'd1);
    rx_expect("b2_rx0", 8'h11);
    rx_expect("b2_rx1", 8'h22);
    rx_expect("b2_rx2", 8'h33);

    // 3: TX full, RX overflow on a six-byte burst, ovf cleared by next start
    push_byte(8'h01, 1'b1);
    push_byte(8'h02, 1'b1);
    push_byte(8'h03, 1'b1);
    push_byte(8'h04, 1'b1);
    check("b3_tx_full", 32'(bus.tx_full), 32'd1);
    push_byte(8'hEE, 1'b0);
    check("b3_tx_full_hold", 32'(bus.tx_full), 32'd1);
    s_wr = wr_cnt;
    start_burst(8'd6);
    repeat (60) @(negedge clk);
    check("b3_stall_state", 32'(dbg_state), 32'(S_LOAD));
    check("b3_stall_wr", 32'(wr_cnt - s_wr), 32'd4);
    check("b3_ovf_before", 32'(bus.rx_ovf), 32'd0);
    check("b3_rx_valid", 32'(bus.rx_valid), 32'(RX_EN));
    push_byte(8'h55, 1'b1);
    push_byte(8'h66, 1'b1);
    wait_xfer_done("b3", 300);
    check("b3_wr_count", 32'(wr_cnt - s_wr), 32'd6);
    check("b3_ovf_set", 32'(bus.rx_ovf), 32'(RX_EN));
    push_byte(8'h77, 1'b1);
    start_burst(8'd1);
    check("b3_ovf_cleared", 32'(bus.rx_ovf), 32'd0);
    wait_xfer_done("b3b", 200);
    check("b3_ovf_again", 32'(bus.rx_ovf), 32'(RX_EN));
    rx_expect("b3_rx0", 8'h01);
    rx_expect("b3_rx1", 8'h02);
    rx_expect("b3_rx2", 8'h03);
    rx_expect("b3_rx3", 8'h04);
    check("b3_rx_empty", 32'(bus.rx_valid), 32'd0);

    // 4: reset during the second byte of a four-byte burst
    push_byte(8'hB1, 1'b1);
    push_byte(8'hB2, 1'b1);
    push_byte(8'hB3, 1'b1);
    push_byte(8'hB4, 1'b1);
    s_wr = wr_cnt;
    start_burst(8'd4);
    k = 0;
    while ((wr_cnt - s_wr) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("b4_second_wr", 32'(wr_cnt - s_wr), 32'd2);
    repeat (2) @(negedge clk);
    s_done = done_cnt;
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    check("b4_rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("b4_rst_busy", 32'(bus.busy), 32'd0);
    check("b4_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("b4_rst_tx_full", 32'(bus.tx_full), 32'd0);
    check("b4_rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("b4_no_xfer_done", 32'(done_cnt - s_done), 32'd0);
    // An emptied TX FIFO leaves a new burst stalled with no eng_wr
    s_wr = wr_cnt; s_done = done_cnt;
    start_burst(8'd1);
    repeat (10) @(negedge clk);
    check("b4_post_rst_stall", 32'(dbg_state), 32'(S_LOAD));
    check("b4_post_rst_wr", 32'(wr_cnt - s_wr), 32'd0);

    // 5: start while busy is ignored (remaining stays 1)
    start_burst(8'd5);
    check("b5_busy_start_state", 32'(dbg_state), 32'(S_LOAD));
    push_byte(8'hC7, 1'b1);
    wait_xfer_done("b5", 200);
    check("b5_wr_count", 32'(wr_cnt - s_wr), 32'd1);
    check("b5_done_count", 32'(done_cnt - s_done), 32'd1);
    rx_expect("b5_rx0", 8'hC7);

    // 6: len=0 start is ignored even with TX data queued
    push_byte(8'hD0, 1'b1);
    s_wr = wr_cnt;
    start_burst(8'd0);
    check("b6_len0_busy", 32'(bus.busy), 32'd0);
    check("b6_len0_cs_n", 32'(bus.cs_n), 32'd1);
    repeat (10) @(negedge clk);
    check("b6_len0_state", 32'(dbg_state), 32'(S_IDLE));
    check("b6_len0_wr", 32'(wr_cnt - s_wr), 32'd0);
    start_burst(8'd1);
    wait_xfer_done("b6", 200);
    check("b6_wr_count", 32'(wr_cnt - s_wr), 32'd1);
    rx_expect("b6_rx0", 8'hD0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
